// File: rtl/uart_bus_pkg.sv
// Shared field map, enums and pack/unpack helpers for the packed
// UART register bus, used by the bus master and the UART responder.
package uart_bus_pkg;

  // to-UART word (bus_o) bit positions
  localparam int AWVALID_B = 0;
  localparam int WVALID_B  = 1;
  localparam int AWADDR_B  = 2;
  localparam int BREADY_B  = 5;
  localparam int WDATA_B   = 6;
  localparam int ARVALID_B = 15;
  localparam int ARADDR_B  = 16;
  localparam int RREADY_B  = 19;
  localparam int M2S_W     = 20;

  // from-UART word (bus_i) bit positions
  localparam int AWREADY_B = 0;
  localparam int WREADY_B  = 1;
  localparam int BVALID_B  = 2;
  localparam int BRESP_B   = 3;
  localparam int ARREADY_B = 5;
  localparam int RVALID_B  = 6;
  localparam int RRESP_B   = 7;
  localparam int RDATA_B   = 9;
  localparam int S2M_W     = 17;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    SLVERR = 2'd2
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    RESP
  } state_t;

  typedef struct packed {
    logic       awvalid;
    logic       wvalid;
    logic [2:0] awaddr;
    logic       bready;
    logic [7:0] wdata;
    logic       arvalid;
    logic [2:0] araddr;
    logic       rready;
  } m2s_t;

  typedef struct packed {
    logic       awready;
    logic       wready;
    logic       bvalid;
    logic [1:0] bresp;
    logic       arready;
    logic       rvalid;
    logic [1:0] rresp;
    logic [7:0] rdata;
  } s2m_t;

  function automatic logic [M2S_W-1:0] pack_m2s(
    input m2s_t m
  );
    logic [M2S_W-1:0] w;
    w = '0;
    w[AWVALID_B]       = m.awvalid;
    w[WVALID_B]        = m.wvalid;
    w[AWADDR_B +: 3]   = m.awaddr;
    w[BREADY_B]        = m.bready;
    w[WDATA_B +: 8]    = m.wdata;
    w[ARVALID_B]       = m.arvalid;
    w[ARADDR_B +: 3]   = m.araddr;
    w[RREADY_B]        = m.rready;
    return w;
  endfunction

  function automatic s2m_t unpack_s2m(
    input logic [S2M_W-1:0] w
  );
    s2m_t s;
    s.awready = w[AWREADY_B];
    s.wready  = w[WREADY_B];
    s.bvalid  = w[BVALID_B];
    s.bresp   = w[BRESP_B +: 2];
    s.arready = w[ARREADY_B];
    s.rvalid  = w[RVALID_B];
    s.rresp   = w[RRESP_B +: 2];
    s.rdata   = w[RDATA_B +: 8];
    return s;
  endfunction

endpackage

// File: rtl/uart_bus_master.sv
// CPU-side initiator: one-outstanding req/rsp port to packed UART bus.
// Ports: clk, rst (sync, active-low), req_*, rsp_*, bus_o, bus_i.
// Optional UART_BUS_TIMEOUT_EN: forced error after TIMEOUT_CYCLES.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int BUS_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_addr,
  input  logic [7:0]       req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_rdata,
  output logic             rsp_err,
  output logic [BUS_W-1:0] bus_o,
  input  logic [BUS_W-1:0] bus_i
);

  state_t     state_q, state_d;
  logic       req_ready_q, req_ready_d;
  logic       awvalid_q, awvalid_d;
  logic       wvalid_q, wvalid_d;
  logic       bready_q, bready_d;
  logic       arvalid_q, arvalid_d;
  logic       rready_q, rready_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_err_q, rsp_err_d;
  logic       done;
  s2m_t       s;
  m2s_t       m;

  assign s = unpack_s2m(bus_i[S2M_W-1:0]);

  logic unused_bus_bits;
  assign unused_bus_bits = ^bus_i[BUS_W-1:S2M_W];

`ifdef UART_BUS_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        busy;
  assign busy = (state_q == WADDR) || (state_q == WRESP) ||
                (state_q == RADDR) || (state_q == RDATA);
`else
  localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    done        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // req_ready_q gates acceptance so nothing is taken
        // in the first cycle after reset release
        if (req_ready_q && req_valid) begin
          addr_d = req_addr;
          if (req_write) begin
            wdata_d   = req_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      WADDR: begin
        if (awvalid_q && s.awready) awvalid_d = 1'b0;
        if (wvalid_q && s.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WRESP;
          done     = 1'b1;
        end
      end
      WRESP: begin
        if (s.bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_err_d   = (s.bresp != OKAY);
          rsp_rdata_d = 8'h00;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
          done        = 1'b1;
        end
      end
      RADDR: begin
        if (s.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
          done      = 1'b1;
        end
      end
      RDATA: begin
        if (s.rvalid) begin
          rsp_rdata_d = s.rdata;
          rsp_err_d   = (s.rresp != OKAY);
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
          done        = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef UART_BUS_TIMEOUT_EN
    tmo_d = busy ? tmo_q + 16'd1 : 16'd0;
    // a handshake completing this cycle beats the timeout
    if (busy && !done &&
        tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = 8'h00;
      rsp_valid_d = 1'b1;
      state_d     = RESP;
      tmo_d       = 16'd0;
    end
`endif

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= 3'd0;
      wdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
`ifdef UART_BUS_TIMEOUT_EN
      tmo_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef UART_BUS_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  // address/data fields are only shown while their valid is up,
  // so an idle bus word is all zero
  always_comb begin
    m         = '0;
    m.awvalid = awvalid_q;
    m.wvalid  = wvalid_q;
    m.awaddr  = awvalid_q ? addr_q : 3'd0;
    m.bready  = bready_q;
    m.wdata   = wvalid_q ? wdata_q : 8'h00;
    m.arvalid = arvalid_q;
    m.araddr  = arvalid_q ? addr_q : 3'd0;
    m.rready  = rready_q;
  end

  assign bus_o = {{(BUS_W-M2S_W){1'b0}}, pack_m2s(m)};

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with a delay-programmable
// UART responder; table of vectors plus reset/spurious sequences.
module tb_uart_bus_master;

`ifdef UART_BUS_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 256;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_addr = 3'd0;
  logic [7:0]  req_wdata = 8'h00;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic [7:0]  rsp_rdata;
  logic [31:0] bus_o;
  logic [31:0] bus_i;

  always #5 clk = ~clk;

  uart_bus_master #(
    .TIMEOUT_CYCLES(TMO),
    .BUS_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .bus_o(bus_o),
    .bus_i(bus_i)
  );

  // bus_o decoded by literal bit positions
  logic       awv, wv, brd, arv, rrd;
  logic [2:0] awa, ara;
  logic [7:0] wd;
  assign awv = bus_o[0];
  assign wv  = bus_o[1];
  assign awa = bus_o[4:2];
  assign brd = bus_o[5];
  assign wd  = bus_o[13:6];
  assign arv = bus_o[15];
  assign ara = bus_o[18:16];
  assign rrd = bus_o[19];

  // responder controls
  int         aw_d = 0, w_d = 0, ar_d = 0, b_d = 0;
  logic [1:0] resp_v = 2'd0;
  logic [7:0] rdata_v = 8'h00;
  logic       spur = 1'b0;
  int         aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0;
  logic       awr, wr_, arr, bv, rv;

  assign awr = awv && (aw_n >= aw_d);
  assign wr_ = wv && (w_n >= w_d);
  assign arr = arv && (ar_n >= ar_d);
  assign bv  = (brd && (b_n >= b_d)) || spur;
  assign rv  = (rrd && (r_n >= b_d)) || spur;
  assign bus_i = {15'd0, rdata_v, resp_v, rv, arr,
                  resp_v, bv, wr_, awr};

  always @(posedge clk) begin
    aw_n <= awv ? aw_n + 1 : 0;
    w_n  <= wv  ? w_n + 1  : 0;
    ar_n <= arv ? ar_n + 1 : 0;
    b_n  <= brd ? b_n + 1  : 0;
    r_n  <= rrd ? r_n + 1  : 0;
  end

  // monitor: valid-high cycles, handshakes, field stability
  logic       clr = 1'b0;
  logic [2:0] cur_addr = 3'd0;
  logic [7:0] cur_wdata = 8'h00;
  int         aw_c = 0, w_c = 0, ar_c = 0, hs_c = 0, bad_c = 0;

  always @(posedge clk) begin
    if (clr) begin
      aw_c  <= 0;
      w_c   <= 0;
      ar_c  <= 0;
      hs_c  <= 0;
      bad_c <= 0;
    end else begin
      aw_c <= aw_c + (awv ? 1 : 0);
      w_c  <= w_c + (wv ? 1 : 0);
      ar_c <= ar_c + (arv ? 1 : 0);
      hs_c <= hs_c + ((brd && bv) ? 1 : 0)
                   + ((rrd && rv) ? 1 : 0);
      bad_c <= bad_c
        + ((awv && awa != cur_addr) ? 1 : 0)
        + ((wv && wd != cur_wdata) ? 1 : 0)
        + ((arv && ara != cur_addr) ? 1 : 0);
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int wr;
    int addr;
    int wdata;
    int aw;
    int w;
    int ar;
    int bd;
    int resp;
    int rdata;
    int hold;
    int lat;
    int erd;
    int eerr;
    int awc;
    int wc;
    int arc;
    int hs;
  } vec_t;

  vec_t tbl[$];

  task automatic run_vec(input vec_t v);
    int lat;
    int sbad;
    @(negedge clk);
    aw_d      = v.aw;
    w_d       = v.w;
    ar_d      = v.ar;
    b_d       = v.bd;
    resp_v    = 2'(v.resp);
    rdata_v   = 8'(v.rdata);
    cur_addr  = 3'(v.addr);
    cur_wdata = 8'(v.wdata);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("req_ready_idle", int'(req_ready), 1);
    req_valid = 1'b1;
    req_write = v.wr[0];
    req_addr  = 3'(v.addr);
    req_wdata = 8'(v.wdata);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    chk("req_ready_busy", int'(req_ready), 0);
    while (!rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, v.lat);
    chk("rsp_rdata", int'(rsp_rdata), v.erd);
    chk("rsp_err", int'(rsp_err), v.eerr);
    sbad = 0;
    for (int k = 0; k < v.hold; k++) begin
      @(negedge clk);
      if (!rsp_valid || int'(rsp_rdata) != v.erd ||
          int'(rsp_err) != v.eerr || req_ready)
        sbad++;
    end
    chk("rsp_hold", sbad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", int'(rsp_valid), 0);
    chk("req_ready_back", int'(req_ready), 1);
    chk("aw_cycles", aw_c, v.awc);
    chk("w_cycles", w_c, v.wc);
    chk("ar_cycles", ar_c, v.arc);
    chk("resp_handshakes", hs_c, v.hs);
    chk("field_stability", bad_c, 0);
  endtask

  initial begin
    // wr addr wdata aw w ar bd resp rdata hold
    //   lat erd eerr awc wc arc hs
    tbl.push_back('{1, 3, 'h83, 0, 0, 0, 0, 0, 'h00, 0,
                    3, 'h00, 0, 1, 1, 0, 1});
    tbl.push_back('{0, 5, 0, 0, 0, 4, 0, 0, 'h60, 0,
                    7, 'h60, 0, 0, 0, 5, 1});
    tbl.push_back('{1, 1, 'h5A, 3, 1, 0, 0, 2, 'h00, 0,
                    6, 'h00, 1, 4, 2, 0, 1});
    tbl.push_back('{0, 2, 0, 0, 0, 0, 2, 2, 'hAB, 0,
                    5, 'hAB, 1, 0, 0, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 'h11, 5,
                    3, 'h11, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 7, 'hFF, 0, 0, 0, 3, 0, 'h77, 2,
                    6, 'h00, 0, 1, 1, 0, 1});
    tbl.push_back('{1, 4, 'h00, 2, 2, 0, 1, 0, 'h00, 0,
                    6, 'h00, 0, 3, 3, 0, 1});
    tbl.push_back('{0, 6, 0, 0, 0, 1, 1, 1, 'hC3, 1,
                    5, 'hC3, 1, 0, 0, 2, 1});
`ifdef UART_BUS_TIMEOUT_EN
    tbl.push_back('{0, 5, 0, 0, 0, 1000, 0, 0, 'h99, 0,
                    9, 'h00, 1, 0, 0, 8, 0});
`endif

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_bus_o", int'(bus_o), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_rdata", int'(rsp_rdata), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", int'(req_ready), 1);

    foreach (tbl[i]) run_vec(tbl[i]);

    // unexpected bvalid/rvalid while idle
    spur = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("spur_rsp_valid", int'(rsp_valid), 0);
    end
    chk("spur_bus_ctl", int'(bus_o & 32'h0008_8023), 0);
    spur = 1'b0;
    run_vec(tbl[0]);

    // reset during RDATA abandons the read
    @(negedge clk);
    ar_d     = 0;
    b_d      = 1000;
    cur_addr = 3'd6;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 3'd6;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("in_rdata_rready", int'(rrd), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_bus_o", int'(bus_o), 0);
    chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
    chk("mid_rst_req_ready", int'(req_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rel_req_ready", int'(req_ready), 1);
    chk("mid_rel_rsp_valid", int'(rsp_valid), 0);
    run_vec(tbl[1]);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- CPU-side initiator for the packed 32-bit AXI-lite-style UART register bus.
- Converts a simple one-outstanding request/response port into bus_o (to UART) handshakes and collects responses from bus_i (from UART).
- Sits between the core's MMIO decode and the 16550-style UART, one instance per UART.

Parameters:
- TIMEOUT_CYCLES, 256: cycles allowed for one transaction before forced error completion (only with UART_BUS_TIMEOUT_EN).
- BUS_W, 32: width of each packed bus word.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = register write, 0 = register read
- req_addr  in  3  UART register index
- req_wdata  in  8  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response accepted
- rsp_rdata  out  8  read data; 0 for writes
- rsp_err  out  1  bresp/rresp != OKAY, or timeout
- bus_o  out  BUS_W  packed to-UART word
- bus_i  in  BUS_W  packed from-UART word

Behaviour:
- bus_o layout: [0] awvalid, [1] wvalid, [4:2] awaddr, [5] bready, [13:6] wdata, [15] arvalid, [18:16] araddr, [19] rready; all other bits 0.
- bus_i layout: [0] awready, [1] wready, [2] bvalid, [4:3] bresp, [5] arready, [6] rvalid, [8:7] rresp, [16:9] rdata; other bits ignored.
- All outputs registered. With rst low at a clock edge:
  - bus_o = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 0.
  - FSM goes to IDLE and the timeout counter clears.
  - req_ready rises the cycle after rst goes high.
- Reset mid-transaction abandons it: no response is produced and bus_o is 0 the next cycle.
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid with req_write = 1: latch addr/data, set awvalid = wvalid = 1, go to WADDR.
  - On req_valid with req_write = 0: set arvalid = 1, go to RADDR.
- WADDR:
  - awvalid drops the cycle after awready is seen high; wvalid drops the cycle after wready is seen high.
  - The two channels are independent; both may complete in the same cycle.
  - Once both are done, assert bready and go to WRESP.
  - awaddr/wdata hold stable while their valid is high.
- WRESP:
  - On bvalid && bready: drop bready, set rsp_err = (bresp != 0), rsp_rdata = 0, go to RESP.
- RADDR:
  - On arready: drop arvalid, assert rready, go to RDATA.
- RDATA:
  - On rvalid: capture rdata, set rsp_err = (rresp != 0), drop rready, go to RESP.
- RESP:
  - rsp_valid = 1; response fields hold until rsp_ready.
  - On rsp_ready: rsp_valid = 0, go to IDLE. The next request is accepted no earlier than the following cycle.
- Minimum latency with an always-ready UART:
  - Write: req accepted cycle 0 → rsp_valid at cycle 3.
  - Read: req accepted cycle 0 → rsp_valid at cycle 3.
- Only one outstanding transaction. Responses that are not expected (bvalid/rvalid outside WRESP/RDATA) are ignored.

Optional Feature:
- Macro: UART_BUS_TIMEOUT_EN.
- Defined:
  - A counter runs in WADDR/WRESP/RADDR/RDATA and clears on entry to IDLE.
  - When it reaches TIMEOUT_CYCLES-1: all bus_o valid/ready bits drop, rsp_err = 1, rsp_rdata = 0, go to RESP.
  - A handshake completing in the same cycle as the timeout wins; normal completion takes priority.
- Undefined: no counter; the FSM waits indefinitely.

Decomposition:
- Package uart_bus_pkg holds:
  - bit-position localparams for both packed words;
  - the resp_t enum (OKAY = 0, SLVERR = 2);
  - the state_t enum;
  - pack/unpack functions.
- The UART responder shares this package.
- No sub-module: a single FSM with a datapath.

Test Plan:
- Write, UART always ready, addr 3, data 0x83, bresp 0:
  - bus_o bits [4:2] = 3 and [13:6] = 0x83 while valid;
  - rsp_valid at cycle 3 with rsp_err = 0.
- Read, addr 5, arready delayed 4 cycles, rdata 0x60:
  - arvalid held stable for 4 cycles;
  - response rsp_rdata = 0x60, rsp_err = 0.
- Write with wready 2 cycles before awready:
  - wvalid drops early while awvalid stays high;
  - exactly one bready handshake; bresp = 2 gives rsp_err = 1.
- rsp_ready held low for 5 cycles:
  - rsp_valid/rsp_rdata stable throughout;
  - req_ready stays 0 until one cycle after rsp_ready.
- rst low during RDATA:
  - next cycle bus_o = 0 and rsp_valid = 0;
  - after release, a new read completes normally.
- With UART_BUS_TIMEOUT_EN and TIMEOUT_CYCLES = 8, UART never responds:
  - rsp_err = 1 after 8 cycles;
  - arvalid deasserted.
